// File: rtl/iob_timer_mc_if.sv
// Native peripheral-bus bundle (valid/address/wdata/wstrb/rdata/ready) for the multi-channel timer.
interface iob_timer_mc_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                valid;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0]   rdata;
    logic                ready;

    modport master (output valid, address, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_timer_mc.sv
// N_CH independent down-counting timers with prescaler, reload, one-shot/auto mode and
// maskable expiry interrupts behind a native-bus register slave.
module iob_timer_mc #(
    parameter  int N_CH   = 4,
    parameter  int CNT_W  = 32,
    parameter  int PRE_W  = 16,
    parameter  int DATA_W = 32,
    localparam int ADDR_W = $clog2(4*N_CH+1)
) (
    input  logic            clk,
    input  logic            rst,
    iob_timer_mc_if.slave   bus,
    output logic            irq,
    output logic [N_CH-1:0] irq_vec
);
    localparam int STRB_W = DATA_W/8;
    localparam int IDX_W  = ADDR_W-2;
    localparam logic [ADDR_W-1:0] PEND_ADDR = ADDR_W'(4*N_CH);

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v, new_v,
                                                      input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int b = 0; b < STRB_W; b++)
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    logic              ready_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [N_CH-1:0]   pend_reg, pend_next, pend_set, pend_clr, ie_vec, irq_vec_reg;
    logic              irq_reg;
    logic              accept, wr, ch_space;
    logic [IDX_W-1:0]  addr_idx;
    logic [1:0]        addr_off;
    logic [DATA_W-1:0] ch_rdata [N_CH];
    logic [DATA_W-1:0] rd_value, clr_word;
    logic              unused_clr;

    // The cycle after an accepted access is the ready cycle and never starts a new one.
    assign accept   = bus.valid && !ready_reg;
    assign wr       = accept && (bus.wstrb != '0);
    assign addr_idx = bus.address[ADDR_W-1:2];
    assign addr_off = bus.address[1:0];
    assign ch_space = bus.address < PEND_ADDR;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic              en_reg, auto_reg, ie_reg;
        logic [PRE_W-1:0]  presc_reg, pre_cnt_reg;
        logic [CNT_W-1:0]  load_reg, count_reg;
        logic              sel, wr_ctrl, wr_presc, wr_load, wr_count, start, tick, expire;
        logic [DATA_W-1:0] ctrl_new, presc_new, load_new, count_new, rd_word;
        logic              unused_hi;

        assign sel      = wr && ch_space && (addr_idx == IDX_W'(gi));
        assign wr_ctrl  = sel && (addr_off == 2'd0);
        assign wr_presc = sel && (addr_off == 2'd1);
        assign wr_load  = sel && (addr_off == 2'd2);
        assign wr_count = sel && (addr_off == 2'd3);

        assign ctrl_new  = merge_bytes(DATA_W'({ie_reg, auto_reg, en_reg}), bus.wdata, bus.wstrb);
        assign presc_new = merge_bytes(DATA_W'(presc_reg), bus.wdata, bus.wstrb);
        assign load_new  = merge_bytes(DATA_W'(load_reg), bus.wdata, bus.wstrb);
        assign count_new = merge_bytes(DATA_W'(count_reg), bus.wdata, bus.wstrb);
        assign unused_hi = ^{ctrl_new, presc_new, load_new, count_new};

        // A bus write to COUNT discards the tick entirely, including a pending expiry.
        assign start  = wr_ctrl && ctrl_new[3];
        assign tick   = !start && en_reg && (pre_cnt_reg == presc_reg);
        assign expire = tick && !wr_count && (count_reg == '0);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                en_reg      <= 1'b0;
                auto_reg    <= 1'b0;
                ie_reg      <= 1'b0;
                presc_reg   <= '0;
                pre_cnt_reg <= '0;
                load_reg    <= '0;
                count_reg   <= '0;
            end else begin
                if (wr_ctrl) begin
                    en_reg   <= ctrl_new[0];
                    auto_reg <= ctrl_new[1];
                    ie_reg   <= ctrl_new[2];
                end
                if (expire && !auto_reg) en_reg <= 1'b0;
                if (wr_presc) presc_reg <= presc_new[PRE_W-1:0];
                if (wr_load)  load_reg  <= load_new[CNT_W-1:0];
                if (start) begin
                    count_reg   <= load_reg;
                    pre_cnt_reg <= '0;
                end else if (en_reg) begin
                    pre_cnt_reg <= tick ? '0 : pre_cnt_reg + 1'b1;
                    if (tick) begin
                        if (count_reg != '0) count_reg <= count_reg - 1'b1;
                        else if (auto_reg)   count_reg <= load_reg;
                    end
                end
                if (wr_count) count_reg <= count_new[CNT_W-1:0];
            end
        end

        always_comb begin
            case (addr_off)
                2'd0:    rd_word = DATA_W'({ie_reg, auto_reg, en_reg});
                2'd1:    rd_word = DATA_W'(presc_reg);
                2'd2:    rd_word = DATA_W'(load_reg);
                default: rd_word = DATA_W'(count_reg);
            endcase
        end

        assign ch_rdata[gi] = rd_word;
        assign pend_set[gi] = expire;
        assign ie_vec[gi]   = ie_reg;
    end

    always_comb begin
        rd_value = '0;
        if (ch_space) begin
            for (int c = 0; c < N_CH; c++)
                if (addr_idx == IDX_W'(c)) rd_value = ch_rdata[c];
        end else if (bus.address == PEND_ADDR) begin
            rd_value = DATA_W'(pend_reg);
        end
    end

    // New expiries take priority over a coincident write-1-to-clear.
    assign clr_word   = (wr && (bus.address == PEND_ADDR)) ? merge_bytes('0, bus.wdata, bus.wstrb) : '0;
    assign pend_clr   = clr_word[N_CH-1:0];
    assign unused_clr = ^clr_word;
    assign pend_next  = (pend_reg & ~pend_clr) | pend_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_reg   <= 1'b0;
            rdata_reg   <= '0;
            pend_reg    <= '0;
            irq_vec_reg <= '0;
            irq_reg     <= 1'b0;
        end else begin
            ready_reg   <= accept;
            rdata_reg   <= (accept && !wr) ? rd_value : '0;
            pend_reg    <= pend_next;
            irq_vec_reg <= pend_reg & ie_vec;
            irq_reg     <= |(pend_reg & ie_vec);
        end
    end

    assign bus.ready = ready_reg;
    assign bus.rdata = rdata_reg;
    assign irq_vec   = irq_vec_reg;
    assign irq       = irq_reg;
endmodule

// File: tb/tb_iob_timer_mc.sv
// Bench for iob_timer_mc: directed scenarios plus random bus traffic against a behavioural model.
module tb_iob_timer_mc;
    localparam int N_CH   = 4;
    localparam int ADDR_W = $clog2(4*N_CH+1);
    localparam int PEND_A = 4*N_CH;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            irq;
    logic [N_CH-1:0] irq_vec;
    int              n_checks = 0;
    int              n_fail = 0;
    bit              run_cmp = 1'b0;
    logic [31:0]     dummy;

    iob_timer_mc_if #(.DATA_W(32), .ADDR_W(ADDR_W)) bus ();

    iob_timer_mc #(.N_CH(N_CH), .CNT_W(32), .PRE_W(16), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus), .irq(irq), .irq_vec(irq_vec));

    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0]     m_count [N_CH];
    logic [31:0]     m_load  [N_CH];
    logic [15:0]     m_presc [N_CH];
    logic [15:0]     m_pre   [N_CH];
    logic            m_en [N_CH], m_auto [N_CH], m_ie [N_CH];
    logic [N_CH-1:0] m_pend, m_irqv;
    logic            m_irq, m_ready;
    logic [31:0]     m_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old_v, new_v, input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input int a);
        int c;
        c = a / 4;
        if (a < PEND_A) begin
            case (a % 4)
                0: return {29'd0, m_ie[c], m_auto[c], m_en[c]};
                1: return {16'd0, m_presc[c]};
                2: return m_load[c];
                default: return m_count[c];
            endcase
        end
        if (a == PEND_A) return 32'(m_pend);
        return 32'd0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_count[c] = 0; m_load[c] = 0; m_presc[c] = 0; m_pre[c] = 0;
            m_en[c] = 0; m_auto[c] = 0; m_ie[c] = 0;
        end
        m_pend = 0; m_irqv = 0; m_irq = 0; m_ready = 0; m_rdata = 0;
    endtask

    task automatic model_step();
        logic acc, wr;
        int a;
        logic [N_CH-1:0] set_v, clr_v, ie_old;
        logic [31:0] rv, tmp;
        acc = bus.valid && !m_ready;
        wr  = acc && (bus.wstrb != 4'h0);
        a   = int'(bus.address);
        rv  = model_read(a);
        set_v = '0;
        clr_v = '0;
        for (int c = 0; c < N_CH; c++) ie_old[c] = m_ie[c];
        for (int c = 0; c < N_CH; c++) begin
            logic [31:0] cnt;
            logic [15:0] pre;
            logic start, wcnt, stop;
            start = wr && (a == 4*c) && bus.wstrb[0] && bus.wdata[3];
            wcnt  = wr && (a == 4*c+3);
            stop  = 1'b0;
            cnt   = m_count[c];
            pre   = m_pre[c];
            if (start) begin
                cnt = m_load[c];
                pre = 0;
            end else if (m_en[c]) begin
                if (m_pre[c] == m_presc[c]) begin
                    pre = 0;
                    if (!wcnt) begin
                        if (m_count[c] != 0) cnt = m_count[c] - 1;
                        else begin
                            set_v[c] = 1'b1;
                            if (m_auto[c]) cnt = m_load[c];
                            else stop = 1'b1;
                        end
                    end
                end else pre = m_pre[c] + 16'd1;
            end
            if (wcnt) cnt = lanes(m_count[c], bus.wdata, bus.wstrb);
            if (wr && (a == 4*c)) begin
                tmp = lanes({29'd0, m_ie[c], m_auto[c], m_en[c]}, bus.wdata, bus.wstrb);
                m_en[c] = tmp[0]; m_auto[c] = tmp[1]; m_ie[c] = tmp[2];
            end
            if (stop) m_en[c] = 1'b0;
            if (wr && (a == 4*c+1)) begin
                tmp = lanes({16'd0, m_presc[c]}, bus.wdata, bus.wstrb);
                m_presc[c] = tmp[15:0];
            end
            if (wr && (a == 4*c+2)) m_load[c] = lanes(m_load[c], bus.wdata, bus.wstrb);
            m_count[c] = cnt;
            m_pre[c]   = pre;
        end
        if (wr && (a == PEND_A)) begin
            tmp   = lanes(32'd0, bus.wdata, bus.wstrb);
            clr_v = tmp[N_CH-1:0];
        end
        m_irqv  = m_pend & ie_old;
        m_irq   = |(m_pend & ie_old);
        m_pend  = (m_pend & ~clr_v) | set_v;
        m_ready = acc;
        m_rdata = (acc && !wr) ? rv : 32'd0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            check("ready", 32'(bus.ready), 32'(m_ready));
            check("rdata", bus.rdata, m_rdata);
            check("irq", 32'(irq), 32'(m_irq));
            check("irq_vec", 32'(irq_vec), 32'(m_irqv));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int a, input logic [31:0] d, input logic [3:0] s);
        bus.valid = 1'b1; bus.address = ADDR_W'(a); bus.wdata = d; bus.wstrb = s;
        @(posedge clk); #1;
        bus.valid = 1'b0; bus.wstrb = 4'h0;
        @(posedge clk); #1;
    endtask

    task automatic bus_read(input int a, output logic [31:0] d);
        bus.valid = 1'b1; bus.address = ADDR_W'(a); bus.wstrb = 4'h0;
        @(posedge clk); #1;
        check("rd_ready", 32'(bus.ready), 32'd1);
        d = bus.rdata;
        bus.valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic read_expect(input string name, input int a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    function automatic logic [31:0] rand_data(input int a);
        if (a < PEND_A && (a % 4) != 0) return 32'($urandom_range(0, 6));
        if (a < PEND_A) return 32'($urandom_range(0, 15));
        return $urandom;
    endfunction

    function automatic logic [3:0] rand_strb();
        if ($urandom_range(0, 3) == 0) return 4'($urandom);
        return 4'hF;
    endfunction

    task automatic burst(input int k);
        int a;
        for (int i = 0; i < k; i++) begin
            a = $urandom_range(0, 31);
            bus.valid = 1'b1; bus.address = ADDR_W'(a); bus.wdata = rand_data(a);
            bus.wstrb = ($urandom_range(0, 1) == 1) ? rand_strb() : 4'h0;
            @(posedge clk); #1;
        end
        bus.valid = 1'b0; bus.wstrb = 4'h0;
        cycles(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.valid = 1'b0; bus.address = '0; bus.wdata = '0; bus.wstrb = '0;
        #2 rst = 1'b0;
        run_cmp = 1'b1;
        cycles(3);
        rst = 1'b1;
        cycles(1);

        // Reset while channel 0 is counting with a pending interrupt
        bus_write(1, 0, 4'hF);
        bus_write(2, 2, 4'hF);
        bus_write(0, 32'hF, 4'hF);
        cycles(8);
        check("pre_reset_irq", 32'(irq), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_irq_vec", 32'(irq_vec), 32'd0);
        @(posedge clk); #1;
        cycles(2);
        rst = 1'b1;
        cycles(1);
        for (int a = 0; a <= PEND_A + 1; a++) read_expect("reg_after_reset", a, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("idle_ready", 32'(bus.ready), 32'd0);
            cycles(1);
        end

        // Channel 0 auto-reload, period 5
        bus_write(1, 0, 4'hF);
        bus_write(2, 4, 4'hF);
        bus_write(0, 32'hF, 4'hF);
        cycles(4);
        check("ch0_irq_early", 32'(irq), 32'd0);
        cycles(1);
        check("ch0_irq_rise", 32'(irq), 32'd1);
        check("ch0_irq_vec", 32'(irq_vec), 32'd1);
        bus_write(PEND_A, 1, 4'hF);
        check("ch0_irq_cleared", 32'(irq), 32'd0);
        cycles(2);
        check("ch0_irq_still_low", 32'(irq), 32'd0);
        cycles(1);
        check("ch0_irq_again", 32'(irq), 32'd1);
        bus_write(0, 0, 4'hF);
        bus_write(PEND_A, 32'hF, 4'hF);

        // Channel 1 one-shot, 12 cycles
        bus_write(5, 2, 4'hF);
        bus_write(6, 3, 4'hF);
        bus_write(4, 32'h9, 4'hF);
        cycles(9);
        read_expect("ch1_pend_before", PEND_A, 32'd0);
        read_expect("ch1_pend_after", PEND_A, 32'd2);
        read_expect("ch1_ctrl_en_off", 4, 32'd0);
        read_expect("ch1_count_zero", 7, 32'd0);
        check("model_ch1_en", 32'(m_en[1]), 32'd0);
        bus_write(PEND_A, 2, 4'hF);
        cycles(20);
        read_expect("ch1_no_rearm", PEND_A, 32'd0);

        // Channel 2 COUNT write on a tick, then W1C colliding with expiry
        bus_write(9, 3, 4'hF);
        bus_write(10, 10, 4'hF);
        bus_write(8, 32'hB, 4'hF);
        cycles(2);
        bus_write(11, 7, 4'hF);
        read_expect("ch2_count_write", 11, 32'd7);
        bus_write(8, 0, 4'hF);
        bus_write(PEND_A, 32'hF, 4'hF);
        bus_write(9, 0, 4'hF);
        bus_write(10, 2, 4'hF);
        bus_write(8, 32'hB, 4'hF);
        cycles(4);
        bus_write(PEND_A, 4, 4'hF);
        read_expect("ch2_w1c_collide", PEND_A, 32'd4);
        check("ch2_masked", 32'(irq_vec), 32'd0);
        bus_write(8, 0, 4'hF);
        bus_write(PEND_A, 32'hF, 4'hF);

        // Byte strobes and undefined addresses
        bus_write(14, 32'hAABBCCDD, 4'b0010);
        read_expect("load_strobe", 14, 32'h0000CC00);
        read_expect("undef_read", PEND_A + 1, 32'd0);
        bus_write(PEND_A + 1, 32'hFFFFFFFF, 4'hF);
        read_expect("pend_after_undef", PEND_A, 32'd0);

        // All channels running, IE only on 1 and 3
        for (int c = 0; c < N_CH; c++) begin
            bus_write(4*c+1, 0, 4'hF);
            bus_write(4*c+2, 32'(2 + c), 4'hF);
        end
        for (int c = 0; c < N_CH; c++) bus_write(4*c, (c % 2 == 1) ? 32'hF : 32'hB, 4'hF);
        cycles(20);
        check("all_irq_vec", 32'(irq_vec), 32'hA);
        check("all_irq", 32'(irq), 32'd1);
        read_expect("all_pend", PEND_A, 32'hF);
        bus_write(4, 3, 4'hF);
        bus_write(12, 3, 4'hF);
        cycles(2);
        check("masked_irq_vec", 32'(irq_vec), 32'd0);
        check("masked_irq", 32'(irq), 32'd0);
        read_expect("pend_kept", PEND_A, 32'hF);
        for (int c = 0; c < N_CH; c++) bus_write(4*c, 0, 4'hF);
        bus_write(PEND_A, 32'hF, 4'hF);

        // Random traffic, checked every cycle against the model
        for (int t = 0; t < 300; t++) begin
            int a;
            a = $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) burst($urandom_range(2, 6));
            else if ($urandom_range(0, 1) == 1) bus_write(a, rand_data(a), rand_strb());
            else bus_read(a, dummy);
            if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 4));
        end

        cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/iob_timer_mc.md
Name: iob_timer_mc

Overview:
- Multi-channel, parametrised successor to the single-counter system timer.
- Provides N_CH independent down-counting timers, each with:
  - a programmable prescaler,
  - a reload value,
  - one-shot or auto-reload mode,
  - a maskable expiry interrupt.
- Sits on the peripheral split as a standard native-bus slave (valid/address/wdata/wstrb/rdata/ready).
- Drives one aggregated interrupt line plus a per-channel interrupt vector.

Parameters:
- N_CH, 4: number of timer channels (1..16).
- CNT_W, 32: counter and reload width (1..DATA_W).
- PRE_W, 16: prescaler width (1..DATA_W).
- DATA_W, 32: bus data width.
- ADDR_W, $clog2(4*N_CH+1): word address width (derived, not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- valid  in  1  bus request
- address  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte write strobes; all-zero means read
- rdata  out  DATA_W  read data
- ready  out  1  request acknowledge
- irq  out  1  OR of all enabled pending channel interrupts
- irq_vec  out  N_CH  per-channel enabled pending interrupts

Behaviour:
- Register map (word addresses), channel c, base 4c:
  - +0 CTRL:
    - bit0 EN
    - bit1 AUTO (1 = reload, 0 = one-shot)
    - bit2 IE
    - bit3 START (write-only, self-clearing, reads 0)
  - +1 PRESC [PRE_W-1:0].
  - +2 LOAD [CNT_W-1:0].
  - +3 COUNT [CNT_W-1:0]: read returns the live value; write forces the value.
- Global register at 4*N_CH, PEND [N_CH-1:0]:
  - read returns pending bits;
  - writing 1 clears the corresponding bit (write-1-to-clear).
- Undefined addresses: reads return 0, writes are ignored, ready is still returned.
- Unimplemented upper bits read 0.
- Bus handshake:
  - ready is asserted exactly 1 cycle after valid is sampled high, for 1 cycle.
  - rdata is valid in that ready cycle; otherwise rdata = 0.
  - valid held for consecutive cycles gives one access per 2 cycles (ready-gap cycle is ignored).
  - Writes honour wstrb per byte lane.
  - Writes take effect on the edge that samples valid.
- Reset (rst = 0, asynchronous): all CTRL, PRESC, LOAD, COUNT, prescaler counters and PEND = 0; ready = 0, rdata = 0, irq = 0, irq_vec = 0.
- Per channel, every cycle:
  - START written 1: COUNT <= LOAD, prescaler <= 0. This overrides tick processing that cycle.
  - Else if EN = 1: prescaler increments. When prescaler == PRESC, prescaler <= 0 and a tick occurs.
  - On a tick:
    - COUNT != 0: COUNT <= COUNT - 1.
    - COUNT == 0: PEND[c] <= 1 (expiry).
      - AUTO = 1: COUNT <= LOAD.
      - AUTO = 0: EN <= 0, COUNT stays 0.
  - EN = 0: prescaler and COUNT hold.
- Period: auto-reload expiry every (LOAD+1)*(PRESC+1) cycles. PRESC = 0 gives a tick every cycle.
- Collisions:
  - bus write to COUNT in the same cycle as a tick: bus value wins, tick discarded.
  - bus write to CTRL.EN = 0 in the same cycle as one-shot expiry: PEND is still set.
  - PEND write-1-clear in the same cycle as a new expiry on that channel: set wins.
  - write to LOAD affects only the next reload/START, never the current COUNT.
- Interrupts (registered, 1 cycle after the PEND/IE change):
  - irq_vec[c] = PEND[c] & IE[c];
  - irq = |irq_vec.
- Clearing IE masks the interrupt but does not clear PEND.
- Channels are fully independent; there is no shared prescaler.

Test Plan:
1. Reset with rst = 0 mid-count (channel 0 counting, PEND = 1) -> on the same edge all outputs = 0; every register reads 0 after release; no ready without valid.
2. Channel 0: PRESC = 0, LOAD = 4, CTRL = AUTO|IE|EN|START -> PEND[0] rises 5 cycles after START, irq 1 cycle later; repeats every 5 cycles. Write PEND = 1 -> irq falls, then rises again on the next expiry.
3. Channel 1: PRESC = 2, LOAD = 3, one-shot -> single expiry 12 cycles after START; CTRL.EN reads 0 afterwards; COUNT reads 0; no further PEND.
4. Channel 2 COUNT write (value 7) aligned with a tick -> COUNT reads 7. PEND write-1-clear coincident with expiry -> PEND stays 1.
5. Byte-strobe write of LOAD with wstrb = 4'b0010, wdata = 0xAABBCCDD onto LOAD = 0 -> LOAD reads 0x0000CC00. Read of address 4*N_CH+1 -> rdata = 0, ready = 1.
6. All 4 channels with different LOAD values and IE set only on channels 1 and 3 -> irq_vec shows only bits 1 and 3; PEND shows all expiries; irq = OR of bits 1 and 3.
